// File: rtl/serial_addsub_if.sv
// serial_addsub_if: handshake and operand/result bundle for serial_addsub.
//   master drives : start, sub, cin, a, b
//   slave drives  : busy, done, sum, cout, ovf
// WIDTH must match the WIDTH of the serial_addsub instance it connects to.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor. It processes DIGIT bits per clock
// and chains a registered carry between digits, so a WIDTH-bit operation takes
// N = WIDTH/DIGIT RUN cycles plus one DONE cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; it aborts any operation in flight
//   bus  serial_addsub_if.slave: start/sub/cin/a/b in; busy/done/sum/cout/ovf out
// sub=1 computes a + ~b + ~cin, which equals a - b - cin (cin acts as borrow-in).
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic           clk,
    input logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_n;
    logic               busy;
    logic               done;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;     // already inverted for subtraction
    logic               carry;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [IDX_W-1:0]   base;
    logic [DIGIT:0]     dsum;
    logic               last;

    // Digit slice selected by the step counter; the LSB digit goes first.
    assign base = IDX_W'(count * DIGIT);
    assign last = (count == CNT_W'(N - 1));
    assign dsum = {1'b0, a_q[base +: DIGIT]}
                + {1'b0, b_q[base +: DIGIT]}
                + {{DIGIT{1'b0}}, carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= bus.sub ? ~bus.b : bus.b;
                        // In sub mode the incoming borrow becomes an inverted carry.
                        carry <= bus.cin ^ bus.sub;
                        count <= '0;
                    end
                end
                RUN: begin
                    sum_q[base +: DIGIT] <= dsum[DIGIT-1:0];
                    carry                <= dsum[DIGIT];
                    if (last) begin
                        cout_q <= dsum[DIGIT];
                        // Carry into the MSB is recovered from the MSB operand and result bits.
                        ovf_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: drives five serial_addsub instances (8/1, 16/4, 4/1, 4/2, 4/4)
// and compares every result against an arithmetic reference model.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [4:0]  start_v = '0, sub_v = '0, cin_v = '0;
    logic [15:0] a_v [5];
    logic [15:0] b_v [5];
    logic [4:0]  busy_o, done_o, cout_o, ovf_o;
    logic [15:0] sum_o [5];

    serial_addsub_if #(.WIDTH(8))  if0 ();
    serial_addsub_if #(.WIDTH(16)) if1 ();
    serial_addsub_if #(.WIDTH(4))  if2 ();
    serial_addsub_if #(.WIDTH(4))  if3 ();
    serial_addsub_if #(.WIDTH(4))  if4 ();

    serial_addsub #(.WIDTH(8),  .DIGIT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_addsub #(.WIDTH(4),  .DIGIT(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    serial_addsub #(.WIDTH(4),  .DIGIT(2)) dut3 (.clk(clk), .rst(rst), .bus(if3));
    serial_addsub #(.WIDTH(4),  .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    assign if0.start = start_v[0]; assign if0.sub = sub_v[0]; assign if0.cin = cin_v[0];
    assign if0.a = a_v[0][7:0];    assign if0.b = b_v[0][7:0];
    assign busy_o[0] = if0.busy;   assign done_o[0] = if0.done;
    assign cout_o[0] = if0.cout;   assign ovf_o[0] = if0.ovf;
    assign sum_o[0] = {8'h00, if0.sum};

    assign if1.start = start_v[1]; assign if1.sub = sub_v[1]; assign if1.cin = cin_v[1];
    assign if1.a = a_v[1];         assign if1.b = b_v[1];
    assign busy_o[1] = if1.busy;   assign done_o[1] = if1.done;
    assign cout_o[1] = if1.cout;   assign ovf_o[1] = if1.ovf;
    assign sum_o[1] = if1.sum;

    assign if2.start = start_v[2]; assign if2.sub = sub_v[2]; assign if2.cin = cin_v[2];
    assign if2.a = a_v[2][3:0];    assign if2.b = b_v[2][3:0];
    assign busy_o[2] = if2.busy;   assign done_o[2] = if2.done;
    assign cout_o[2] = if2.cout;   assign ovf_o[2] = if2.ovf;
    assign sum_o[2] = {12'h000, if2.sum};

    assign if3.start = start_v[3]; assign if3.sub = sub_v[3]; assign if3.cin = cin_v[3];
    assign if3.a = a_v[3][3:0];    assign if3.b = b_v[3][3:0];
    assign busy_o[3] = if3.busy;   assign done_o[3] = if3.done;
    assign cout_o[3] = if3.cout;   assign ovf_o[3] = if3.ovf;
    assign sum_o[3] = {12'h000, if3.sum};

    assign if4.start = start_v[4]; assign if4.sub = sub_v[4]; assign if4.cin = cin_v[4];
    assign if4.a = a_v[4][3:0];    assign if4.b = b_v[4][3:0];
    assign busy_o[4] = if4.busy;   assign done_o[4] = if4.done;
    assign cout_o[4] = if4.cout;   assign ovf_o[4] = if4.ovf;
    assign sum_o[4] = {12'h000, if4.sum};

    function automatic int wid(input int idx);
        case (idx)
            0:       return 8;
            1:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int nsteps(input int idx);
        case (idx)
            0:       return 8;
            1:       return 4;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: whole-word integer arithmetic, signed overflow from range.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c,
                         output logic [15:0] es, output logic eco, output logic eov);
        longint mask = (longint'(1) << w) - 1;
        longint ua   = longint'(a) & mask;
        longint ub   = s ? (~longint'(b) & mask) : (longint'(b) & mask);
        longint ci   = longint'(c ^ s);
        longint t    = ua + ub + ci;
        longint half = longint'(1) << (w - 1);
        longint sa   = (ua >= half) ? ua - (mask + 1) : ua;
        longint sb   = (ub >= half) ? ub - (mask + 1) : ub;
        longint st   = sa + sb + ci;
        es  = 16'(t & mask);
        eco = ((t >> w) & 1) != 0;
        eov = (st > half - 1) || (st < -half);
    endtask

    // Called at a negedge with the instance idle; returns at a negedge with it idle.
    task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic c, input logic [15:0] es,
                         input logic eco, input logic eov, input string tag);
        int n    = nsteps(idx);
        int cyc  = 0;
        int bcnt = 0;
        bit seen = 0;
        a_v[idx] = a; b_v[idx] = b; sub_v[idx] = s; cin_v[idx] = c;
        start_v[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[idx] = 1'b0;
        a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom);
        sub_v[idx] = 1'($urandom); cin_v[idx] = 1'($urandom);
        for (int i = 1; i <= 40; i++) begin
            cyc = i;
            if (busy_o[idx]) bcnt++;
            if (done_o[idx]) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(cyc), 32'(n + 1));
        check({tag, ".busy_cycles"}, 32'(bcnt), 32'(n + 1));
        check({tag, ".sum"}, 32'(sum_o[idx]), 32'(es));
        check({tag, ".cout"}, 32'(cout_o[idx]), 32'(eco));
        check({tag, ".ovf"}, 32'(ovf_o[idx]), 32'(eov));
        @(negedge clk);
        check({tag, ".idle_busy"}, 32'(busy_o[idx]), 32'd0);
        check({tag, ".idle_done"}, 32'(done_o[idx]), 32'd0);
        check({tag, ".sum_hold"}, 32'(sum_o[idx]), 32'(es));
    endtask

    task automatic op_model(input int idx, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic c, input string tag);
        logic [15:0] es;
        logic        eco, eov;
        model(wid(idx), a, b, s, c, es, eco, eov);
        do_op(idx, a, b, s, c, es, eco, eov, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] es;
        logic        eco, eov;
        logic [15:0] qs [$];
        logic        qc [$];
        logic        qo [$];
        int          last_done;
        int          got;
        int          dones;

        for (int i = 0; i < 5; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset%0d.busy", i), 32'(busy_o[i]), 32'd0);
            check($sformatf("reset%0d.done", i), 32'(done_o[i]), 32'd0);
            check($sformatf("reset%0d.sum", i), 32'(sum_o[i]), 32'd0);
            check($sformatf("reset%0d.cout", i), 32'(cout_o[i]), 32'd0);
            check($sformatf("reset%0d.ovf", i), 32'(ovf_o[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived results.
        do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ff_01");
        do_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, "add_7f_01");
        do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0, "sub_05_07");
        do_op(0, 16'h0080, 16'h0001, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1, "sub_80_01");
        do_op(0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, "sub_10_00_borrow");
        do_op(1, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, "w16_add");
        do_op(1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "w16_cin");

        // Exhaustive 4-bit sweep for every digit size.
        for (int idx = 2; idx <= 4; idx++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int sc = 0; sc < 4; sc++)
                        op_model(idx, 16'(a), 16'(b), sc[1], sc[0], $sformatf("ex%0d", idx));

        // Random operands on the wide instances.
        for (int k = 0; k < 40; k++) begin
            op_model(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rnd8");
            op_model(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rnd16");
        end

        // start held high: one accept per N+2 cycles; operands churn every cycle.
        last_done = -1;
        got = 0;
        for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
            if (done_o[0]) begin
                if (qs.size() == 0) begin
                    check("cont.unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("cont.sum", 32'(sum_o[0]), 32'(qs.pop_front()));
                    check("cont.cout", 32'(cout_o[0]), 32'(qc.pop_front()));
                    check("cont.ovf", 32'(ovf_o[0]), 32'(qo.pop_front()));
                end
                if (last_done >= 0) check("cont.period", 32'(cyc - last_done), 32'd10);
                last_done = cyc;
                got++;
            end
            a_v[0] = 16'($urandom & 32'hFF); b_v[0] = 16'($urandom & 32'hFF);
            sub_v[0] = 1'($urandom); cin_v[0] = 1'($urandom);
            if (!busy_o[0] && got < 3) begin
                model(8, a_v[0], b_v[0], sub_v[0], cin_v[0], es, eco, eov);
                qs.push_back(es); qc.push_back(eco); qo.push_back(eov);
            end
            start_v[0] = (got < 3);
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        check("cont.results", 32'(got), 32'd3);
        check("cont.leftover", 32'(qs.size()), 32'd0);
        repeat (2) @(negedge clk);

        // Reset during RUN step 3 of 8 aborts the operation.
        do_op(0, 16'h0080, 16'h0001, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1, "pre_abort");
        a_v[0] = 16'h00FF; b_v[0] = 16'h0001; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", 32'(busy_o[0]), 32'd0);
        check("abort.done", 32'(done_o[0]), 32'd0);
        check("abort.sum", 32'(sum_o[0]), 32'd0);
        check("abort.cout", 32'(cout_o[0]), 32'd0);
        check("abort.ovf", 32'(ovf_o[0]), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o[0]) dones++;
        end
        check("abort.no_done", 32'(dones), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
